// File: rtl/data_mem_responder_if.sv
// Load/store bus between a core (master) and the data memory responder (slave).
// req_*: request channel (valid/ready); rsp_*: response channel (valid/ready).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_addr, req_wdata,
    output req_write, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_wdata,
    input  req_write, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency 64-bit data memory answering RISC-V loads/stores (B/H/W/D).
// Ports: clk, reset (async, active-low), bus (slave side of the request/response bus).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [2:0]    w_lane;
  logic [5:0]    w_sh;
  logic [63:0]   w_word;
  logic [63:0]   w_shr;
  logic [63:0]   w_wsh;
  logic [63:0]   w_bits;
  logic [63:0]   w_merged;
  logic [63:0]   w_load;
  logic [7:0]    w_size;
  logic [7:0]    w_bmask;
  logic          w_mis;
  logic          w_oob;
  logic          w_bad;
  logic          w_err;

  assign w_idx  = r_addr[3 +: AW];
  assign w_lane = r_addr[2:0];
  assign w_sh   = {w_lane, 3'b000};
  assign w_word = r_mem[w_idx];
  assign w_shr  = w_word >> w_sh;
  assign w_wsh  = r_wdata << w_sh;

  // Any address bit above the word index means past the end.
  assign w_oob = |r_addr[63:AW+3];

  always_comb begin
    w_size = 8'h01;
    w_mis  = 1'b0;
    unique case (r_f3[1:0])
      2'b00: begin
        w_size = 8'h01;
        w_mis  = 1'b0;
      end
      2'b01: begin
        w_size = 8'h03;
        w_mis  = r_addr[0];
      end
      2'b10: begin
        w_size = 8'h0F;
        w_mis  = |r_addr[1:0];
      end
      default: begin
        w_size = 8'hFF;
        w_mis  = |r_addr[2:0];
      end
    endcase
  end

  // 111 is undefined; unsigned variants make no sense for stores.
  assign w_bad = (r_f3 == 3'b111)
               | (r_write & r_f3[2]);
  assign w_err = w_mis | w_oob | w_bad;

  assign w_bmask = w_size << w_lane;

  always_comb begin
    w_bits = '0;
    for (int i = 0; i < 8; i++) begin
      w_bits[8*i +: 8] = {8{w_bmask[i]}};
    end
  end

  assign w_merged = (w_word & ~w_bits)
                  | (w_wsh & w_bits);

  always_comb begin
    w_load = '0;
    unique case (r_f3)
      3'b000: w_load = {{56{w_shr[7]}},  w_shr[7:0]};
      3'b001: w_load = {{48{w_shr[15]}}, w_shr[15:0]};
      3'b010: w_load = {{32{w_shr[31]}}, w_shr[31:0]};
      3'b011: w_load = w_shr;
      3'b100: w_load = {56'd0, w_shr[7:0]};
      3'b101: w_load = {48'd0, w_shr[15:0]};
      3'b110: w_load = {32'd0, w_shr[31:0]};
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_f3    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_write <= bus.req_write;
            r_f3    <= bus.req_funct3;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_err   <= w_err;
            r_rdata <= (w_err | r_write) ? '0 : w_load;
            if (!w_err && r_write) begin
              r_mem[w_idx] <= w_merged;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_error = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instances at LATENCY 1, 2 and 15 on shared stimulus.
// Instance 1 (LATENCY 2) carries the vector table and the scoreboard.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid;
  logic        req_write;
  logic        rsp_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_funct3;

  logic [2:0]  v_rdy;
  logic [2:0]  v_rv;
  logic [2:0]  v_err;
  logic [63:0] v_rd [3];

  int lat_of [3] = '{1, 2, 15};

  for (genvar g = 0; g < 3; g++) begin : g_inst
    data_mem_responder_if u_if ();
    assign u_if.req_valid  = req_valid;
    assign u_if.req_addr   = req_addr;
    assign u_if.req_wdata  = req_wdata;
    assign u_if.req_write  = req_write;
    assign u_if.req_funct3 = req_funct3;
    assign u_if.rsp_ready  = rsp_ready;
    assign v_rdy[g] = u_if.req_ready;
    assign v_rv[g]  = u_if.rsp_valid;
    assign v_err[g] = u_if.rsp_error;
    assign v_rd[g]  = u_if.rsp_rdata;
    data_mem_responder #(
      .DEPTH_WORDS(64),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 15))
    ) u_dut (
      .clk(clk),
      .reset(rst_n),
      .bus(u_if.slave)
    );
  end

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic void chk(bit ok, string nm,
                              logic [63:0] act,
                              logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endfunction

  function automatic void add(logic wr, logic [2:0] f3,
                              logic [63:0] a, logic [63:0] wd,
                              logic [63:0] rd, logic er);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = a;
    v.wdata = wd; v.rdata = rd; v.err = er;
    tbl.push_back(v);
  endfunction

  function automatic void push(logic [63:0] d, logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    q.push_back(x);
  endfunction

  // Scoreboard: compare the LATENCY-2 instance at each response handshake.
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && v_rv[1] && rsp_ready) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_rsp", v_rd[1], 64'd0);
      end else begin
        m_e = q.pop_front();
        chk(v_rd[1] == m_e.d, "rsp_rdata", v_rd[1], m_e.d);
        chk(v_err[1] == m_e.e, "rsp_error",
            64'(v_err[1]), 64'(m_e.e));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!v_rdy[1] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!v_rdy[1]) chk(1'b0, "ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!v_rv[1] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic scramble();
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
    req_write  = ~req_write;
    req_funct3 = 3'($urandom);
  endtask

  task automatic xfer(input vec_t v);
    int n;
    wait_idle();
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    push(v.rdata, v.err);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    chk(!v_rdy[1], "accept", 64'(v_rdy[1]), 64'd0);
    wait_rsp(n);
    chk(n == 2, "latency", 64'(n), 64'd2);
    @(posedge clk); #1;
    chk(!v_rv[1], "rsp_drop", 64'(v_rv[1]), 64'd0);
  endtask

  task automatic probe(input logic wr, input logic [63:0] a,
                       input logic [63:0] wd,
                       input logic [63:0] rd);
    int          lat [3];
    logic [63:0] got [3];
    logic        ge  [3];
    int          n = 0;
    while (v_rdy != 3'b111 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(v_rdy == 3'b111, "probe_ready", 64'(v_rdy), 64'd7);
    req_write  = wr;
    req_funct3 = 3'b011;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    push(rd, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      got[i] = '0;
      ge[i]  = 1'b0;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0 && v_rv[i]) begin
          lat[i] = k;
          got[i] = v_rd[i];
          ge[i]  = v_err[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk(lat[i] == lat_of[i],
          $sformatf("probe_lat_L%0d", lat_of[i]),
          64'(lat[i]), 64'(lat_of[i]));
      chk(got[i] == rd,
          $sformatf("probe_rd_L%0d", lat_of[i]),
          got[i], rd);
      chk(ge[i] == 1'b0,
          $sformatf("probe_err_L%0d", lat_of[i]),
          64'(ge[i]), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b1;

    add(1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 0);
    add(0, 3'b011, 64'h10, 64'hFFFF, 64'h1122334455667788, 0);
    add(1, 3'b000, 64'h13, 64'h80, 64'h0, 0);
    add(0, 3'b000, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFF80, 0);
    add(0, 3'b100, 64'h13, 64'h0, 64'h80, 0);
    add(0, 3'b011, 64'h10, 64'h0, 64'h1122334480667788, 0);
    add(0, 3'b010, 64'h12, 64'h0, 64'h0, 1);
    add(0, 3'b011, 64'h200, 64'h0, 64'h0, 1);
    add(0, 3'b011, 64'h10, 64'h0, 64'h1122334480667788, 0);
    add(1, 3'b001, 64'h1E, 64'hBEEF, 64'h0, 0);
    add(0, 3'b011, 64'h18, 64'h0, 64'hBEEF000000000000, 0);
    add(0, 3'b001, 64'h1E, 64'h0, 64'hFFFFFFFFFFFFBEEF, 0);
    add(0, 3'b101, 64'h1E, 64'h0, 64'hBEEF, 0);
    add(1, 3'b010, 64'h14, 64'h89ABCDEF, 64'h0, 0);
    add(0, 3'b011, 64'h10, 64'h0, 64'h89ABCDEF80667788, 0);
    add(0, 3'b010, 64'h14, 64'h0, 64'hFFFFFFFF89ABCDEF, 0);
    add(0, 3'b110, 64'h14, 64'h0, 64'h0000000089ABCDEF, 0);
    add(0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF89, 0);
    add(0, 3'b100, 64'h11, 64'h0, 64'h77, 0);
    add(0, 3'b001, 64'h10, 64'h0, 64'h7788, 0);
    add(0, 3'b111, 64'h10, 64'h0, 64'h0, 1);
    add(1, 3'b100, 64'h10, 64'h55, 64'h0, 1);
    add(1, 3'b011, 64'h0C, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1);
    add(1, 3'b001, 64'h11, 64'hFFFF, 64'h0, 1);
    add(0, 3'b011, 64'h08, 64'h0, 64'h0, 0);
    add(0, 3'b011, 64'h10, 64'h0, 64'h89ABCDEF80667788, 0);
    add(0, 3'b011, 64'h1F8, 64'h0, 64'h0, 0);
    add(1, 3'b011, 64'h1F8, 64'hDEADBEEFCAFEF00D, 64'h0, 0);
    add(0, 3'b011, 64'h1F8, 64'h0, 64'hDEADBEEFCAFEF00D, 0);
    add(0, 3'b011, 64'h8000000000000010, 64'h0, 64'h0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk(v_rv[1] == 1'b0, "rst_valid", 64'(v_rv[1]), 64'd0);
    chk(v_rd[1] == 64'd0, "rst_rdata", v_rd[1], 64'd0);
    chk(v_err[1] == 1'b0, "rst_error", 64'(v_err[1]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(v_rdy == 3'b111, "rst_ready", 64'(v_rdy), 64'd7);

    foreach (tbl[i]) xfer(tbl[i]);

    // Response held off for 5 cycles while a new request waits.
    wait_idle();
    rsp_ready  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = 64'h10;
    req_valid  = 1'b1;
    push(64'h89ABCDEF80667788, 1'b0);
    @(posedge clk); #1;
    req_addr = 64'h08;
    wait_rsp(n);
    chk(n == 2, "hold_latency", 64'(n), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(v_rv[1] == 1'b1, "hold_valid", 64'(v_rv[1]), 64'd1);
      chk(v_rd[1] == 64'h89ABCDEF80667788, "hold_rdata",
          v_rd[1], 64'h89ABCDEF80667788);
      chk(v_err[1] == 1'b0, "hold_error", 64'(v_err[1]), 64'd0);
      chk(v_rdy[1] == 1'b0, "hold_ready", 64'(v_rdy[1]), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    push(64'h0, 1'b0);
    @(posedge clk); #1;
    chk(v_rv[1] == 1'b0, "hs_valid", 64'(v_rv[1]), 64'd0);
    chk(v_rdy[1] == 1'b1, "hs_ready", 64'(v_rdy[1]), 64'd1);
    @(posedge clk); #1;
    chk(v_rdy[1] == 1'b0, "second_accept", 64'(v_rdy[1]), 64'd0);
    req_valid = 1'b0;
    wait_rsp(n);
    chk(n == 2, "second_latency", 64'(n), 64'd2);
    @(posedge clk); #1;

    // Reset in the middle of a store.
    wait_idle();
    req_write  = 1'b1;
    req_funct3 = 3'b011;
    req_addr   = 64'h08;
    req_wdata  = 64'hAAAA;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk(v_rdy[1] == 1'b0, "mid_wait", 64'(v_rdy[1]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk(v_rdy[1] == 1'b1, "mid_rst_ready", 64'(v_rdy[1]), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(v_rv[1] == 1'b0, "no_rsp", 64'(v_rv[1]), 64'd0);
    end
    begin
      vec_t v;
      v.wr = 0; v.f3 = 3'b011; v.addr = 64'h08;
      v.wdata = 0; v.rdata = 0; v.err = 0;
      xfer(v);
      v.addr = 64'h10;
      xfer(v);
    end

    // Timing across all three latencies.
    probe(1'b1, 64'h10, 64'h1122334455667788, 64'h0);
    probe(1'b0, 64'h10, 64'h0, 64'h1122334455667788);

    repeat (3) @(posedge clk);
    #1;
    chk(q.size() == 0, "queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set the number of 64-bit storage words; power of two, 2..1024.
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request accept to response valid; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate the core presents a load/store request.
REQ-006 req_ready  output  1  SHALL indicate the block can accept a request this cycle.
REQ-007 req_addr  input  64  SHALL carry the byte address.
REQ-008 req_wdata  input  64  SHALL carry store data, right-aligned (byte in [7:0], half in [15:0], word in [31:0]).
REQ-009 req_write  input  1  SHALL select store (1) or load (0).
REQ-010 req_funct3  input  3  SHALL select size/extension: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-011 rsp_valid  output  1  SHALL indicate a response is presented.
REQ-012 rsp_ready  input  1  SHALL indicate the core accepts the response.
REQ-013 rsp_rdata  output  64  SHALL carry load data, sign- or zero-extended per funct3; 0 for stores and errors.
REQ-014 rsp_error  output  1  SHALL flag a rejected request, valid with rsp_valid.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 Request accepted when req_valid & req_ready at a rising edge; addr, wdata, write and funct3 latched; latency counter loaded with LATENCY-1; state -> WAIT.
REQ-017 In WAIT, counter decrements each edge; at the edge where counter==0, the access is performed and state -> RESP.
REQ-018 Request accepted at edge N SHALL give rsp_valid=1 immediately after edge N+LATENCY.
REQ-019 Word index = addr[3 +: log2(DEPTH_WORDS)]; byte lane = addr[2:0]; little-endian lane order.
REQ-020 Store SHALL update only the addressed bytes (1/2/4/8) of the word; other bytes unchanged.
REQ-021 Load SHALL extract addressed bytes; funct3 000/001/010 sign-extend, 100/101/110 zero-extend, 011 returns full word.
REQ-022 Error if: addr not aligned to access size; addr >= DEPTH_WORDS*8; funct3=111; store with funct3[2]=1. On error: memory unchanged, rsp_rdata=0, rsp_error=1.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_error SHALL hold stable until rsp_valid & rsp_ready at an edge, then state -> IDLE and rsp_valid=0.
REQ-024 A request is never accepted in the same cycle a response completes; earliest next accept is the edge after the response handshake (minimum spacing LATENCY+2 cycles).
REQ-025 Inputs other than req_valid are ignored outside IDLE; changes after acceptance SHALL NOT affect the in-flight access.
REQ-026 Load following a store to the same address SHALL return the stored data.

Reset
REQ-027 While reset=0: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_error=0, all memory words 0; req_ready=1 after reset deasserts.
REQ-028 Reset asserted mid-operation SHALL abandon the in-flight request with no memory write and no response.

Verification
REQ-029 After reset, store D 0x1122334455667788 to 0x10, then load D 0x10 -> rsp_rdata 0x1122334455667788, rsp_error 0, rsp_valid rises exactly LATENCY edges after each accept.
REQ-030 Store B 0x80 to 0x13, load B 0x13 -> 0xFFFFFFFFFFFFFF80; load BU 0x13 -> 0x80; load D 0x10 -> 0x1122334480667788.
REQ-031 Load W at 0x12 (misaligned) and load D at DEPTH_WORDS*8 -> rsp_error 1, rsp_rdata 0; subsequent load D 0x10 unchanged.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp outputs stable, req_ready 0, no second accept until one edge after the handshake.
REQ-033 Assert reset during WAIT of store D 0xAAAA to 0x08 -> no response, load D 0x08 after release returns 0.
REQ-034 Repeat REQ-029 with LATENCY=1 and LATENCY=15 -> response timing matches REQ-018.
